// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives a one-cycle-latency instruction ROM and
// presents a registered {valid, inst, pc} to IF/ID. A one-entry skid buffer
// absorbs the word that is already in flight when decode stalls, and a
// redirect squashes everything held or in flight and refetches at the target.
module fetch_stage #(
    parameter int              INST_W   = 26,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [INST_W-1:0] rom_q,
    output logic              valid_out,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    logic [PC_W-1:0]   pc_q;
    logic              infl_v;
    logic [PC_W-1:0]   infl_pc;
    logic              skid_v;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;

    logic              hold;
    logic              issue;
    logic [1:0]        squash_inc;
    logic [CNT_W+1:0]  squash_sum;

    // Issue decision and ROM address. While held, a new read is only allowed
    // when nothing is buffered or in flight, so the skid can never overflow.
    always_comb begin
        hold       = stall & valid_out;
        issue      = !rst & (redirect | !hold | (!skid_v & !infl_v));
        rom_addr   = pc_q;
        if (rst)
            rom_addr = RESET_PC;
        else if (redirect)
            rom_addr = redirect_pc;
        squash_inc = 2'(valid_out) + 2'(skid_v) + 2'(infl_v);
        squash_sum = {2'b00, squash_cnt} + (CNT_W+2)'(squash_inc);
    end

    // PC and outstanding-read tracking; pc wraps naturally modulo 2^PC_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            infl_v  <= 1'b0;
            infl_pc <= '0;
        end else if (issue) begin
            pc_q    <= rom_addr + PC_W'(1);
            infl_v  <= 1'b1;
            infl_pc <= rom_addr;
        end else begin
            infl_v  <= 1'b0;
        end
    end

    // Output register and skid: skid drains first to keep fetch order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            inst_out  <= '0;
            pc_out    <= '0;
            skid_v    <= 1'b0;
            skid_inst <= '0;
            skid_pc   <= '0;
        end else if (redirect) begin
            // Arriving rom_q is dropped; the target was issued this cycle.
            valid_out <= 1'b0;
            skid_v    <= 1'b0;
        end else if (!hold) begin
            if (skid_v) begin
                valid_out <= 1'b1;
                inst_out  <= skid_inst;
                pc_out    <= skid_pc;
                skid_v    <= infl_v;
                if (infl_v) begin
                    skid_inst <= rom_q;
                    skid_pc   <= infl_pc;
                end
            end else if (infl_v) begin
                valid_out <= 1'b1;
                inst_out  <= rom_q;
                pc_out    <= infl_pc;
                skid_v    <= 1'b0;
            end else begin
                valid_out <= 1'b0;
                skid_v    <= 1'b0;
            end
        end else if (infl_v) begin
            // Held: the in-flight word parks in the (known empty) skid.
            skid_v    <= 1'b1;
            skid_inst <= rom_q;
            skid_pc   <= infl_pc;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (issue && fetch_cnt != '1)
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (redirect) begin
                if (squash_sum[CNT_W+1:CNT_W] != 2'b00)
                    squash_cnt <= '1;
                else
                    squash_cnt <= squash_sum[CNT_W-1:0];
            end
        end
    end

endmodule
